// File: rtl/pixel_frame_buf.sv
// pixel_frame_buf
//   Captures one 256-pixel frame from the serial-to-pixel stage, then drains it
//   to a downstream consumer with a valid/ready handshake, one pixel per cycle.
//   Addresses never written in the frame read back as 8'h00 (a written-flag
//   vector masks the unreset storage).
//
// Ports
//   clk, reset            rising-edge clock, async active-high reset
//   pixel_wr/addr/dataout pixel write port (honoured in FILL only)
//   pixel_finish          upstream frame-complete flag
//   rd_start              begin draining a captured frame (READY only)
//   rd_ready              downstream accepts rd_data this cycle
//   rd_valid/data/addr    drain output, rd_last marks address 255
//   frame_done            frame captured, not yet drained
//   wr_count              distinct addresses written this frame (0..256)
//   ovw_err, late_err     sticky rewrite / write-outside-FILL flags
//   chksum                mod-2^16 sum of drained bytes
//
// Build option
//   PFB_CHECKSUM_EN  when defined, chksum accumulates drained bytes; otherwise
//                    chksum is tied to zero and no adder exists.

module pixel_frame_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_wr,
  input  logic [7:0]  pixel_addr,
  input  logic [7:0]  pixel_dataout,
  input  logic        pixel_finish,
  input  logic        rd_start,
  input  logic        rd_ready,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic [7:0]  rd_addr,
  output logic        rd_last,
  output logic        frame_done,
  output logic [8:0]  wr_count,
  output logic        ovw_err,
  output logic        late_err,
  output logic [15:0] chksum
);

  typedef enum logic [1:0] {S_FILL, S_READY, S_DRAIN} state_e;

  state_e       state_q, state_d;
  logic [255:0] flags_q, flags_d;
  logic [8:0]   wr_count_q, wr_count_d;
  logic         ovw_q, ovw_d, late_q, late_d;
  logic         rd_valid_q, rd_valid_d;
  logic [7:0]   rd_addr_q, rd_addr_d;
  logic [7:0]   rd_data_q;
  logic         rd_load;
  logic         mem_we;

  logic [7:0]   mem [256];

  always_comb begin
    state_d    = state_q;
    flags_d    = flags_q;
    wr_count_d = wr_count_q;
    ovw_d      = ovw_q;
    late_d     = late_q;
    rd_valid_d = rd_valid_q;
    rd_addr_d  = rd_addr_q;
    rd_load    = 1'b0;
    mem_we     = 1'b0;
    unique case (state_q)
      S_FILL: begin
        if (pixel_wr) begin
          mem_we = 1'b1;
          if (flags_q[pixel_addr]) begin
            ovw_d = 1'b1;
          end else begin
            flags_d[pixel_addr] = 1'b1;
            wr_count_d          = wr_count_q + 9'd1;
          end
        end
        // a write in the same cycle as pixel_finish still lands above
        if (pixel_finish || wr_count_d == 9'd256) state_d = S_READY;
      end
      S_READY: begin
        if (pixel_wr) late_d = 1'b1;
        if (rd_start) begin
          state_d    = S_DRAIN;
          rd_valid_d = 1'b1;
          rd_addr_d  = 8'd0;
          rd_load    = 1'b1;
        end
      end
      S_DRAIN: begin
        if (pixel_wr) late_d = 1'b1;
        if (rd_ready) begin
          if (rd_addr_q == 8'hFF) begin
            state_d    = S_FILL;
            rd_valid_d = 1'b0;
            rd_addr_d  = 8'd0;
            flags_d    = '0;
            wr_count_d = 9'd0;
            ovw_d      = 1'b0;
            late_d     = 1'b0;
          end else begin
            // prefetch the next pixel during the transfer: no bubble
            rd_addr_d = rd_addr_q + 8'd1;
            rd_load   = 1'b1;
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FILL;
      flags_q    <= '0;
      wr_count_q <= 9'd0;
      ovw_q      <= 1'b0;
      late_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      wr_count_q <= wr_count_d;
      ovw_q      <= ovw_d;
      late_q     <= late_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  // storage carries no reset; the flags decide what is visible
  always_ff @(posedge clk) begin
    if (mem_we) mem[pixel_addr] <= pixel_dataout;
  end

  // registered read; flags are stable outside FILL, so reading them here is safe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data_q <= 8'h00;
    else if (rd_load) rd_data_q <= flags_q[rd_addr_d] ? mem[rd_addr_d] : 8'h00;
  end

`ifdef PFB_CHECKSUM_EN
  logic [15:0] chksum_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) chksum_q <= 16'h0000;
    else if (state_q == S_READY && rd_start) chksum_q <= 16'h0000;
    else if (state_q == S_DRAIN && rd_ready) chksum_q <= chksum_q + {8'h00, rd_data_q};
  end
  assign chksum = chksum_q;
`else
  assign chksum = 16'h0000;
`endif

  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign rd_addr    = rd_addr_q;
  assign rd_last    = rd_valid_q & (rd_addr_q == 8'hFF);
  assign frame_done = (state_q == S_READY);
  assign wr_count   = wr_count_q;
  assign ovw_err    = ovw_q;
  assign late_err   = late_q;

endmodule
